uart_rx_core: RTL and testbench

- Single-clock UART receive engine that converts the serial line into bytes.
- Sits directly downstream of the receive-side baud timing. Instead of running on a divided clock, it counts DIV_FACTOR system cycles per bit internally, so the whole receive path stays in the clk_in domain.
- Delivers each received byte through a valid/ready handshake to the controller.
- Flags framing, parity and overrun errors.

---
 rtl/uart_rx_core.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: single-clock UART receiver with internal bit timing.
// Bytes leave through valid/ready; errors are one-cycle pulses.
//
// Ports:
//   clk_in      system clock, posedge
//   reset_n     asynchronous active-low reset
//   DIV_FACTOR  clk_in cycles per bit (values below 4 act as 4)
//   rx_in       asynchronous serial line, idle high
//   rx_data     received byte, zero-extended when DATA_BITS < 8
//   rx_valid    rx_data holds an undelivered byte
//   rx_ready    consumer takes the byte when rx_valid && rx_ready
//   frame_err   pulse: stop bit sampled low
//   parity_err  pulse: parity mismatch
//   overrun_err pulse: good byte dropped, previous one still pending
//   busy        receiver is inside a frame
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic [31:0] DIV_FACTOR,
    input  logic        rx_in,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_err,
    output logic        parity_err,
    output logic        overrun_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t               state;
    logic                 sync1;
    logic                 sync2;
    logic                 rx_d;
    logic [31:0]          div_q;
    logic [31:0]          cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bad;

    logic                 start_edge;
    logic [31:0]          div_clamp;
    logic [31:0]          half_m1;
    logic [31:0]          full_m1;
    logic [7:0]           shift_ext;

    // Falling edge seen after the synchronizer; a line held low
    // can never look like a fresh edge.
    assign start_edge = ~sync2 & rx_d;
    assign div_clamp  = (DIV_FACTOR < 32'd4) ? 32'd4 : DIV_FACTOR;
    assign half_m1    = (div_q >> 1) - 32'd1;
    assign full_m1    = div_q - 32'd1;

    always_comb begin
        shift_ext = '0;
        shift_ext[DATA_BITS-1:0] = shift;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
            rx_d  <= sync2;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            div_q       <= '0;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            par_bad     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        div_q   <= div_clamp;
                        cnt     <= '0;
                        bit_idx <= '0;
                        par_bad <= 1'b0;
                        state   <= START;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == half_m1) begin
                        cnt <= '0;
                        if (sync2) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                DATA: begin
                    if (cnt == full_m1) begin
                        cnt <= '0;
                        // LSB first: new bit enters at the top
                        if (DATA_BITS > 1) begin
                            shift <= {sync2, shift[DATA_BITS-1:1]};
                        end else begin
                            shift <= DATA_BITS'(sync2);
                        end
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            if (PARITY_EN) begin
                                state <= PARITY;
                            end else begin
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                PARITY: begin
                    if (cnt == full_m1) begin
                        cnt     <= '0;
                        par_bad <= (sync2 != ((^shift) ^ PARITY_ODD));
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                STOP: begin
                    if (cnt == full_m1) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!sync2) begin
                            frame_err <= 1'b1;
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
                        end else if (rx_valid && !rx_ready) begin
                            overrun_err <= 1'b1;
                        end else begin
                            // also covers a same-cycle accept
                            rx_data  <= shift_ext;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table vectors, corner sequences and random frames
// for uart_rx_core, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_core;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic [31:0] div_f;
    logic [1:0]  rx_l;
    logic [1:0]  rdy;
    wire  [7:0]  dat0;
    wire  [7:0]  dat1;
    wire  [1:0]  vld;
    wire  [1:0]  fe;
    wire  [1:0]  pe;
    wire  [1:0]  oe;
    wire  [1:0]  bsy;

    always #5 clk_in = ~clk_in;

    uart_rx_core #(
        .DATA_BITS (8),
        .PARITY_EN (1'b0),
        .PARITY_ODD(1'b0)
    ) u_a (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .DIV_FACTOR (div_f),
        .rx_in      (rx_l[0]),
        .rx_data    (dat0),
        .rx_valid   (vld[0]),
        .rx_ready   (rdy[0]),
        .frame_err  (fe[0]),
        .parity_err (pe[0]),
        .overrun_err(oe[0]),
        .busy       (bsy[0])
    );

    uart_rx_core #(
        .DATA_BITS (8),
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b0)
    ) u_b (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .DIV_FACTOR (div_f),
        .rx_in      (rx_l[1]),
        .rx_data    (dat1),
        .rx_valid   (vld[1]),
        .rx_ready   (rdy[1]),
        .frame_err  (fe[1]),
        .parity_err (pe[1]),
        .overrun_err(oe[1]),
        .busy       (bsy[1])
    );

    int n_chk = 0;
    int n_fail = 0;

    // observed
    int         fe_cnt[2];
    int         pe_cnt[2];
    int         oe_cnt[2];
    int         acc_n[2];
    logic [7:0] acc_buf[2][128];
    logic [1:0] prev_v;
    logic [1:0] prev_t;
    logic [7:0] prev_d[2];

    // reference model
    int         exp_fe[2];
    int         exp_pe[2];
    int         exp_oe[2];
    int         exp_n[2];
    logic [7:0] exp_buf[2][128];
    bit         pending[2];
    logic [7:0] pend_data[2];
    int         last_chk[2];

    typedef struct {
        int         d;
        logic [7:0] data;
        bit         par;
        bit         stop;
        bit         ready;
        int         div;
        int         ek;
    } vec_t;

    vec_t vt[10];

    function automatic logic [7:0] dat_of(input int d);
        return (d == 0) ? dat0 : dat1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp_v, exp_v);
        end
    endtask

    task automatic set_ready(input int d, input bit r);
        rdy[d] = r;
        if (r && pending[d]) begin
            exp_buf[d][exp_n[d]] = pend_data[d];
            exp_n[d]++;
            pending[d] = 1'b0;
        end
    endtask

    // outcome of one frame from the line-level rules
    task automatic model_frame(input int d, input logic [7:0] data,
                               input bit par, input bit stop);
        bit par_ok;
        par_ok = (d == 0) || (par == (^data));
        if (!stop) begin
            exp_fe[d]++;
        end else if (!par_ok) begin
            exp_pe[d]++;
        end else if (pending[d] && !rdy[d]) begin
            exp_oe[d]++;
        end else if (rdy[d]) begin
            exp_buf[d][exp_n[d]] = data;
            exp_n[d]++;
        end else begin
            pending[d]   = 1'b1;
            pend_data[d] = data;
        end
    endtask

    task automatic bit_out(input int d, input bit b, input int per);
        rx_l[d] = b;
        repeat (per) @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input int d, input logic [7:0] data,
                              input bit par, input bit stop,
                              input int per, input int new_div);
        bit_out(d, 1'b0, per);
        if (new_div >= 0) div_f = 32'(new_div);
        for (int i = 0; i < 8; i++) bit_out(d, data[i], per);
        if (d == 1) bit_out(d, par, per);
        bit_out(d, stop, per);
        rx_l[d] = 1'b1;
        repeat (per + 6) @(posedge clk_in);
        #1;
    endtask

    task automatic check_frame(input int d);
        chk($sformatf("acc_count%0d", d), acc_n[d], exp_n[d]);
        for (int i = last_chk[d]; i < exp_n[d]; i++) begin
            chk($sformatf("acc_data%0d[%0d]", d, i),
                int'(acc_buf[d][i]), int'(exp_buf[d][i]));
        end
        last_chk[d] = exp_n[d];
        chk($sformatf("frame_err_cnt%0d", d), fe_cnt[d], exp_fe[d]);
        chk($sformatf("parity_err_cnt%0d", d), pe_cnt[d], exp_pe[d]);
        chk($sformatf("overrun_cnt%0d", d), oe_cnt[d], exp_oe[d]);
        chk($sformatf("busy_idle%0d", d), int'(bsy[d]), 0);
    endtask

    task automatic run(input int d, input logic [7:0] data, input bit par,
                       input bit stop, input bit ready, input int div,
                       input int new_div);
        int per;
        per   = (div < 4) ? 4 : div;
        div_f = 32'(div);
        set_ready(d, ready);
        model_frame(d, data, par, stop);
        send_frame(d, data, par, stop, per, new_div);
        check_frame(d);
    endtask

    // bus monitor: error pulses, accepted bytes, data hold
    initial begin
        prev_v = '0;
        prev_t = '0;
        forever begin
            @(negedge clk_in);
            if (!reset_n) begin
                prev_v = '0;
                prev_t = '0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    fe_cnt[d] += int'(fe[d]);
                    pe_cnt[d] += int'(pe[d]);
                    oe_cnt[d] += int'(oe[d]);
                    if (prev_v[d] && !prev_t[d]) begin
                        n_chk++;
                        if (!(vld[d] && dat_of(d) == prev_d[d])) begin
                            n_fail++;
                            $display("FAIL hold%0d: valid=%b data=%h expected valid=1 data=%h",
                                     d, vld[d], dat_of(d), prev_d[d]);
                        end
                    end
                    if (vld[d] && rdy[d] && acc_n[d] < 128) begin
                        acc_buf[d][acc_n[d]] = dat_of(d);
                        acc_n[d]++;
                    end
                    prev_v[d] = vld[d];
                    prev_t[d] = vld[d] && rdy[d];
                    prev_d[d] = dat_of(d);
                end
            end
        end
    end

    initial begin
        int cnt_b;
        bit seen_b;
        for (int d = 0; d < 2; d++) begin
            fe_cnt[d] = 0; pe_cnt[d] = 0; oe_cnt[d] = 0; acc_n[d] = 0;
            exp_fe[d] = 0; exp_pe[d] = 0; exp_oe[d] = 0; exp_n[d] = 0;
            pending[d] = 1'b0; pend_data[d] = '0; last_chk[d] = 0;
        end

        vt[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 16, 0};
        vt[1] = '{0, 8'h55, 1'b0, 1'b0, 1'b1, 16, 1};
        vt[2] = '{0, 8'h12, 1'b0, 1'b1, 1'b1, 16, 0};
        vt[3] = '{0, 8'h11, 1'b0, 1'b1, 1'b0, 16, 0};
        vt[4] = '{0, 8'h22, 1'b0, 1'b1, 1'b0, 16, 3};
        vt[5] = '{0, 8'h3C, 1'b0, 1'b1, 1'b1, 2, 0};
        vt[6] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 16, 0};
        vt[7] = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 16, 2};
        vt[8] = '{1, 8'hFF, 1'b0, 1'b1, 1'b1, 5, 0};
        vt[9] = '{1, 8'h80, 1'b1, 1'b0, 1'b1, 7, 1};

        reset_n = 1'b0;
        div_f   = 32'd16;
        rx_l    = 2'b11;
        rdy     = 2'b11;
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_valid", int'(vld), 0);
        chk("reset_data", int'({dat1, dat0}), 0);
        chk("reset_busy", int'(bsy), 0);
        chk("reset_errs", int'({fe, pe, oe}), 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;

        // table vectors
        for (int i = 0; i < 10; i++) begin
            int f0, p0, o0;
            f0 = fe_cnt[vt[i].d];
            p0 = pe_cnt[vt[i].d];
            o0 = oe_cnt[vt[i].d];
            run(vt[i].d, vt[i].data, vt[i].par, vt[i].stop,
                vt[i].ready, vt[i].div, -1);
            chk($sformatf("vec%0d_fe", i), fe_cnt[vt[i].d] - f0,
                (vt[i].ek == 1) ? 1 : 0);
            chk($sformatf("vec%0d_pe", i), pe_cnt[vt[i].d] - p0,
                (vt[i].ek == 2) ? 1 : 0);
            chk($sformatf("vec%0d_oe", i), oe_cnt[vt[i].d] - o0,
                (vt[i].ek == 3) ? 1 : 0);
            if (vt[i].ek == 3) begin
                chk("overrun_kept_valid", int'(vld[0]), 1);
                chk("overrun_kept_data", int'(dat0), int'(pend_data[0]));
            end
        end

        // false start: 3-cycle glitch, busy for 8 cycles
        div_f = 32'd16;
        set_ready(0, 1'b1);
        rx_l[0] = 1'b0;
        cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            #1;
            if (i == 2) rx_l[0] = 1'b1;
            cnt_b += int'(bsy[0]);
        end
        chk("false_start_busy_cycles", cnt_b, 8);
        check_frame(0);
        run(0, 8'h3C, 1'b0, 1'b1, 1'b1, 16, -1);

        // break: stop low, line held low, no retrigger
        exp_fe[0]++;
        bit_out(0, 1'b0, 16);
        for (int i = 0; i < 8; i++) bit_out(0, i[0], 16);
        rx_l[0] = 1'b0;
        seen_b  = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk_in);
            #1;
            if (i >= 16) seen_b |= bsy[0];
        end
        chk("break_no_retrigger", int'(seen_b), 0);
        rx_l[0] = 1'b1;
        repeat (20) @(posedge clk_in);
        #1;
        check_frame(0);
        run(0, 8'h12, 1'b0, 1'b1, 1'b1, 16, -1);

        // reset in the middle of a frame with a byte pending
        run(0, 8'h5A, 1'b0, 1'b1, 1'b0, 16, -1);
        chk("pre_reset_valid", int'(vld[0]), 1);
        bit_out(0, 1'b0, 16);
        bit_out(0, 1'b1, 16);
        bit_out(0, 1'b0, 8);
        chk("pre_reset_busy", int'(bsy[0]), 1);
        reset_n = 1'b0;
        #1;
        chk("midreset_data", int'(dat0), 0);
        chk("midreset_valid", int'(vld[0]), 0);
        chk("midreset_busy", int'(bsy[0]), 0);
        chk("midreset_errs", int'({fe[0], pe[0], oe[0]}), 0);
        pending[0] = 1'b0;
        rx_l[0] = 1'b1;
        repeat (5) @(posedge clk_in);
        #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clk_in);
        #1;
        check_frame(0);

        // divisor change mid-frame, then the new divisor
        run(0, 8'hF0, 1'b0, 1'b1, 1'b1, 16, 2);
        run(0, 8'h0F, 1'b0, 1'b1, 1'b1, 2, -1);

        // random frames against the model
        for (int n = 0; n < 40; n++) begin
            int d;
            d = int'($urandom_range(0, 1));
            run(d, 8'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 12)), -1);
        end
        set_ready(0, 1'b1);
        set_ready(1, 1'b1);
        repeat (5) @(posedge clk_in);
        #1;
        check_frame(0);
        check_frame(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
